// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared RV32I pipeline definitions: opcodes, NOP encoding, hazard FSM states
// and the per-stage control bundle driven by the hazard sequencer.
package rv_pipe_pkg;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic       uses_rs1;
    logic       uses_rs2;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } src_info_t;

  typedef struct packed {
    logic pc_we;
    logic d_we;
    logic x_we;
    logic m_we;
    logic d_nop;
    logic x_nop;
    logic w_nop;
  } ctl_t;

  // Control patterns, fields ordered pc/d/x/m write enables then d/x/w nops.
  localparam ctl_t CTL_RESET  = 7'b0000_111;
  localparam ctl_t CTL_FREEZE = 7'b0000_001;
  localparam ctl_t CTL_RUN    = 7'b1111_000;
  localparam ctl_t CTL_FLUSH  = 7'b1111_110;
  localparam ctl_t CTL_BUBBLE = 7'b0011_010;
  localparam ctl_t CTL_DROP   = 7'b1111_001;

  function automatic logic is_mem_op(input logic [6:0] opcode);
    return (opcode == LOAD) || (opcode == STORE);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller: stage instructions and
// memory handshake in, stage enables / NOP strobes / counters out.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      insd;
  logic [31:0]      insx;
  logic [31:0]      insm;
  logic             br_taken;
  logic             mem_ack;
  logic             pc_we;
  logic             d_we;
  logic             x_we;
  logic             m_we;
  logic             d_nop;
  logic             x_nop;
  logic             w_nop;
  logic             mem_req;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output insd, insx, insm, br_taken, mem_ack,
    input  pc_we, d_we, x_we, m_we, d_nop, x_nop, w_nop,
    input  mem_req, mem_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  insd, insx, insm, br_taken, mem_ack,
    output pc_we, d_we, x_we, m_we, d_nop, x_nop, w_nop,
    output mem_req, mem_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_src_decode.sv
// Register-operand decode of one RV32I instruction: which sources are read,
// and the rs1/rs2/rd fields.
module hz_src_decode
  import rv_pipe_pkg::*;
(
  input  logic [31:0] insn_i,
  output src_info_t   info_o
);

  logic [6:0] opcode;
  logic       unused_fields;

  assign opcode        = insn_i[6:0];
  assign unused_fields = ^{insn_i[31:25], insn_i[14:12]};

  // NOTE: every always_comb output is assigned on all paths, so no latch is inferred.
  always_comb begin
    info_o.uses_rs1 = !((opcode == LUI) || (opcode == AUIPC) || (opcode == JAL));
    info_o.uses_rs2 = (opcode == OP) || (opcode == STORE) || (opcode == BRANCH);
    info_o.rs1      = insn_i[19:15];
    info_o.rs2      = insn_i[24:20];
    info_o.rd       = insn_i[11:7];
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipe: load-use bubbles,
// redirect flushes, memory-wait freeze with timeout, and perf counters.
module pipe_hazard_ctrl
  import rv_pipe_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              clk,
  input  logic              rest,
  pipe_hazard_ctrl_if.slave bus
);

  localparam logic [TO_W-1:0] TIMEOUT_V = TO_W'(TIMEOUT);

  src_info_t d_info;
  src_info_t x_info;

  state_e           state_q, state_d;
  logic [TO_W-1:0]  timer_q, timer_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic             mem_timeout_q;

  ctl_t ctl;
  logic mem_req;
  logic load_use;
  logic flush_evt;
  logic timeout_evt;
  logic unused_bits;

  hz_src_decode u_dec_d (
    .insn_i (bus.insd),
    .info_o (d_info)
  );

  hz_src_decode u_dec_x (
    .insn_i (bus.insx),
    .info_o (x_info)
  );

  assign unused_bits = ^{bus.insm[31:7], x_info.uses_rs1, x_info.uses_rs2,
                         x_info.rs1, x_info.rs2};

  assign load_use = (bus.insx[6:0] == LOAD) && (x_info.rd != 5'd0) &&
                    ((d_info.uses_rs1 && (d_info.rs1 == x_info.rd)) ||
                     (d_info.uses_rs2 && (d_info.rs2 == x_info.rd)));

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    ctl         = CTL_RUN;
    mem_req     = 1'b0;
    flush_evt   = 1'b0;
    timeout_evt = 1'b0;
    if (!rest) begin
      // Outputs follow reset combinationally; the FSM is cleared at the edge.
      ctl = CTL_RESET;
    end else begin
      unique case (state_q)
        RUN: begin
          mem_req = is_mem_op(bus.insm[6:0]);
          if (mem_req && !bus.mem_ack) begin
            ctl     = CTL_FREEZE;
            state_d = MEM_WAIT;
            timer_d = TO_W'(1);
          end else if (bus.br_taken) begin
            ctl       = CTL_FLUSH;
            flush_evt = 1'b1;
          end else if (load_use) begin
            ctl = CTL_BUBBLE;
          end
        end
        MEM_WAIT: begin
          mem_req = 1'b1;
          if (bus.mem_ack) begin
            ctl     = CTL_RUN;
            state_d = RUN;
            timer_d = '0;
          end else if (timer_q == TIMEOUT_V) begin
            ctl         = CTL_DROP;
            state_d     = RUN;
            timer_d     = '0;
            timeout_evt = 1'b1;
          end else begin
            ctl     = CTL_FREEZE;
            timer_d = timer_q + TO_W'(1);
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rest) begin
      state_q       <= RUN;
      timer_q       <= '0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      if (!ctl.pc_we && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (flush_evt && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
      if (timeout_evt) begin
        mem_timeout_q <= 1'b1;
      end
    end
  end

  assign bus.pc_we       = ctl.pc_we;
  assign bus.d_we        = ctl.d_we;
  assign bus.x_we        = ctl.x_we;
  assign bus.m_we        = ctl.m_we;
  assign bus.d_nop       = ctl.d_nop;
  assign bus.x_nop       = ctl.x_nop;
  assign bus.w_nop       = ctl.w_nop;
  assign bus.mem_req     = mem_req;
  assign bus.mem_timeout = mem_timeout_q;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios with literal expectations plus
// random traffic compared every cycle against a rule-level model.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W   = 6;
  localparam int TIMEOUT = 4;
  localparam int TO_W    = 3;
  localparam int CMAX    = (1 << CNT_W) - 1;

  localparam logic [31:0] T_NOP    = 32'h00000013;
  localparam logic [31:0] LW_X5    = 32'h0000A283;
  localparam logic [31:0] ADD_X6X5 = 32'h00228333;
  localparam logic [31:0] LW_X0    = 32'h0000A003;
  localparam logic [31:0] ADD_X6X0 = 32'h00200333;
  localparam logic [31:0] SW_X2    = 32'h0020A023;

  logic clk = 1'b0;
  logic rest = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   armed   = 1'b0;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clk  (clk),
    .rest (rest),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One pipeline cycle: inputs change just after the edge, return once outputs settle.
  task automatic drive(input logic r, input logic [31:0] d, input logic [31:0] x,
                       input logic [31:0] m, input logic br, input logic ack);
    @(posedge clk);
    #1;
    rest         = r;
    bus.insd     = d;
    bus.insx     = x;
    bus.insm     = m;
    bus.br_taken = br;
    bus.mem_ack  = ack;
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, T_NOP, T_NOP, T_NOP, 1'b0, 1'b0);
  endtask

  // ---------------- behavioural reference model ----------------
  function automatic bit reads_rs1(input logic [6:0] op);
    case (op)
      7'b0110111, 7'b0010111, 7'b1101111: return 1'b0;
      default:                            return 1'b1;
    endcase
  endfunction

  function automatic bit reads_rs2(input logic [6:0] op);
    case (op)
      7'b0110011, 7'b0100011, 7'b1100011: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  int   m_frozen = 0;
  int   m_stall  = 0;
  int   m_flush  = 0;
  bit   m_to     = 1'b0;
  bit   lu, is_mem, flush_now, timeout_now;
  logic [7:0] exp_ctl, act_ctl;

  always @(negedge clk) begin
    lu = (bus.insx[6:0] == 7'b0000011) && (bus.insx[11:7] != 5'd0) &&
         ((reads_rs1(bus.insd[6:0]) && bus.insd[19:15] == bus.insx[11:7]) ||
          (reads_rs2(bus.insd[6:0]) && bus.insd[24:20] == bus.insx[11:7]));
    is_mem      = (bus.insm[6:0] == 7'b0000011) || (bus.insm[6:0] == 7'b0100011);
    flush_now   = 1'b0;
    timeout_now = 1'b0;
    // {pc_we, d_we, x_we, m_we, d_nop, x_nop, w_nop, mem_req}
    if (!rest) begin
      exp_ctl = 8'b0000_1110;
    end else if (m_frozen > 0) begin
      if (bus.mem_ack) exp_ctl = 8'b1111_0001;
      else if (m_frozen == TIMEOUT) begin
        exp_ctl     = 8'b1111_0011;
        timeout_now = 1'b1;
      end else exp_ctl = 8'b0000_0011;
    end else if (is_mem && !bus.mem_ack) begin
      exp_ctl = 8'b0000_0011;
    end else if (bus.br_taken) begin
      exp_ctl   = {7'b1111_110, is_mem};
      flush_now = 1'b1;
    end else if (lu) begin
      exp_ctl = {7'b0011_010, is_mem};
    end else begin
      exp_ctl = {7'b1111_000, is_mem};
    end

    act_ctl = {bus.pc_we, bus.d_we, bus.x_we, bus.m_we,
               bus.d_nop, bus.x_nop, bus.w_nop, bus.mem_req};
    if (armed) begin
      check("ctl", 32'(act_ctl), 32'(exp_ctl));
      check("stall_cnt", 32'(bus.stall_cnt), 32'(m_stall));
      check("flush_cnt", 32'(bus.flush_cnt), 32'(m_flush));
      check("mem_timeout", 32'(bus.mem_timeout), 32'(m_to));
    end

    if (!rest) begin
      m_frozen = 0;
      m_stall  = 0;
      m_flush  = 0;
      m_to     = 1'b0;
    end else begin
      if (!exp_ctl[7] && m_stall < CMAX) m_stall++;
      if (flush_now && m_flush < CMAX) m_flush++;
      if (timeout_now) m_to = 1'b1;
      m_frozen = (exp_ctl[7:4] == 4'b0000) ? m_frozen + 1 : 0;
    end
  end

  // ---------------- random stimulus helpers ----------------
  function automatic logic [31:0] rand_insn(input bit mem_bias);
    logic [6:0] op;
    int sel;
    sel = mem_bias && ($urandom_range(0, 9) < 4) ? $urandom_range(0, 1) : $urandom_range(0, 9);
    case (sel)
      0: op = 7'b0000011;
      1: op = 7'b0100011;
      2: op = 7'b1100011;
      3: op = 7'b1101111;
      4: op = 7'b1100111;
      5: op = 7'b0110111;
      6: op = 7'b0010111;
      7: op = 7'b0110011;
      8: op = 7'b0010011;
      default: op = 7'($urandom);
    endcase
    return {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            3'($urandom), 5'($urandom_range(0, 3)), op};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.insd = T_NOP; bus.insx = T_NOP; bus.insm = T_NOP;
    bus.br_taken = 1'b0; bus.mem_ack = 1'b0;
    @(posedge clk);
    armed = 1'b1;

    // Reset pattern and cleared state
    do_reset();
    check("rst_pc_we", 32'(bus.pc_we), 32'd0);
    check("rst_nops", 32'({bus.d_nop, bus.x_nop, bus.w_nop}), 32'h7);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);

    // 1: load-use bubble
    drive(1'b1, ADD_X6X5, LW_X5, T_NOP, 1'b0, 1'b0);
    check("lu_pc_d_we", 32'({bus.pc_we, bus.d_we}), 32'h0);
    check("lu_x_m_we", 32'({bus.x_we, bus.m_we}), 32'h3);
    check("lu_x_nop", 32'(bus.x_nop), 32'd1);
    drive(1'b1, T_NOP, T_NOP, T_NOP, 1'b0, 1'b0);
    check("lu_stall_cnt", 32'(bus.stall_cnt), 32'd1);
    check("lu_released", 32'(bus.pc_we), 32'd1);

    // 2: load into x0 never stalls
    do_reset();
    drive(1'b1, ADD_X6X0, LW_X0, T_NOP, 1'b0, 1'b0);
    check("x0_all_we", 32'({bus.pc_we, bus.d_we, bus.x_we, bus.m_we}), 32'hF);
    check("x0_nops", 32'({bus.d_nop, bus.x_nop, bus.w_nop}), 32'h0);

    // 3: redirect overrides load-use
    do_reset();
    drive(1'b1, ADD_X6X5, LW_X5, T_NOP, 1'b1, 1'b0);
    check("br_nops", 32'({bus.d_nop, bus.x_nop}), 32'h3);
    check("br_pc_we", 32'(bus.pc_we), 32'd1);
    drive(1'b1, T_NOP, T_NOP, T_NOP, 1'b0, 1'b0);
    check("br_flush_cnt", 32'(bus.flush_cnt), 32'd1);
    check("br_stall_cnt", 32'(bus.stall_cnt), 32'd0);

    // 4: store waits three cycles then acks
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, T_NOP, T_NOP, SW_X2, 1'b0, 1'b0);
      check("sw_frozen", 32'({bus.pc_we, bus.w_nop, bus.mem_req}), 32'h3);
    end
    drive(1'b1, T_NOP, T_NOP, SW_X2, 1'b0, 1'b1);
    check("sw_release", 32'({bus.pc_we, bus.m_we, bus.w_nop}), 32'h6);
    drive(1'b1, T_NOP, T_NOP, T_NOP, 1'b0, 1'b0);
    check("sw_stall_cnt", 32'(bus.stall_cnt), 32'd3);

    // 5: load never acked times out after TIMEOUT frozen cycles
    do_reset();
    for (int i = 0; i < TIMEOUT; i++) begin
      drive(1'b1, T_NOP, T_NOP, LW_X5, 1'b0, 1'b0);
      check("to_frozen", 32'(bus.pc_we), 32'd0);
    end
    drive(1'b1, T_NOP, T_NOP, LW_X5, 1'b0, 1'b0);
    check("to_drop", 32'({bus.pc_we, bus.w_nop}), 32'h3);
    drive(1'b1, T_NOP, T_NOP, T_NOP, 1'b0, 1'b0);
    check("to_sticky", 32'(bus.mem_timeout), 32'd1);
    check("to_stall_cnt", 32'(bus.stall_cnt), 32'd4);

    // 6: reset aborts a wait
    drive(1'b1, T_NOP, T_NOP, LW_X5, 1'b0, 1'b0);
    drive(1'b1, T_NOP, T_NOP, LW_X5, 1'b0, 1'b0);
    check("abort_still_sticky", 32'(bus.mem_timeout), 32'd1);
    drive(1'b0, T_NOP, T_NOP, LW_X5, 1'b0, 1'b0);
    check("abort_rst_pattern", 32'({bus.pc_we, bus.mem_req, bus.w_nop}), 32'h1);
    drive(1'b1, T_NOP, T_NOP, T_NOP, 1'b0, 1'b0);
    check("abort_run", 32'({bus.pc_we, bus.mem_req}), 32'h2);
    check("abort_to_clr", 32'(bus.mem_timeout), 32'd0);
    check("abort_cnt_clr", 32'(bus.stall_cnt), 32'd0);

    // Counter saturation
    do_reset();
    for (int i = 0; i < 100; i++) drive(1'b1, T_NOP, T_NOP, LW_X5, 1'b0, 1'b0);
    drive(1'b1, T_NOP, T_NOP, T_NOP, 1'b0, 1'b0);
    check("stall_sat", 32'(bus.stall_cnt), 32'(CMAX));
    do_reset();
    for (int i = 0; i < 70; i++) drive(1'b1, T_NOP, T_NOP, T_NOP, 1'b1, 1'b0);
    drive(1'b1, T_NOP, T_NOP, T_NOP, 1'b0, 1'b0);
    check("flush_sat", 32'(bus.flush_cnt), 32'(CMAX));
    check("flush_sat_stall", 32'(bus.stall_cnt), 32'd0);

    // Random traffic, checked each cycle by the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      drive(($urandom_range(0, 999) >= 3),
            rand_insn(1'b0), rand_insn(1'b1), rand_insn(1'b1),
            ($urandom_range(0, 9) < 2), ($urandom_range(0, 99) < 35));
    end

    @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
